// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared widths and types for the rv32i pipeline.
// Holds the datapath/register-address widths, the data memory depth, the
// performance counter width and the M/W pipeline register layout.
package rv32i_pkg;

  localparam int DPW        = 32;   // datapath width
  localparam int ADW        = 5;    // register address width
  localparam int DMEM_DEPTH = 256;  // data memory depth in words, power of 2
  localparam int CNTW       = 16;   // load/store counter width

  // M/W pipeline register contents
  typedef struct packed {
    logic           regwrite;
    logic           resultsrc;
    logic [DPW-1:0] aluresult;
    logic [DPW-1:0] readdata;
    logic [4:0]     rd;
  } mw_reg_t;

  // True when a byte address is not word aligned
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: bundle between the M stage of top and mem_wb_stage.
// M-stage side (master drives): regwriteM, resultsrcM, memwriteM,
//   aluresultM, Rd2M, RdM.
// W-stage side (slave drives): addr_3, we, wd_3 (reg-file write port),
//   RdW, regwriteW (hazard unit), resultW (forwarding),
//   load_cnt, store_cnt, misalign_err (status).
// Parameter CNTW sets the counter width.
interface mem_wb_stage_if #(
  parameter int CNTW = rv32i_pkg::CNTW
);
  import rv32i_pkg::*;

  logic            regwriteM;
  logic            resultsrcM;
  logic            memwriteM;
  logic [DPW-1:0]  aluresultM;
  logic [DPW-1:0]  Rd2M;
  logic [4:0]      RdM;

  logic [ADW-1:0]  addr_3;
  logic            we;
  logic [DPW-1:0]  wd_3;
  logic [4:0]      RdW;
  logic            regwriteW;
  logic [DPW-1:0]  resultW;
  logic [CNTW-1:0] load_cnt;
  logic [CNTW-1:0] store_cnt;
  logic            misalign_err;

  modport master (
    output regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM,
    input  addr_3, we, wd_3, RdW, regwriteW, resultW,
    input  load_cnt, store_cnt, misalign_err
  );

  modport slave (
    input  regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM,
    output addr_3, we, wd_3, RdW, regwriteW, resultW,
    output load_cnt, store_cnt, misalign_err
  );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// data_mem: word-addressed data memory for the rv32i pipeline.
// One synchronous write port, one asynchronous (combinational) read port.
// Contents are not reset. A read of the address being written in the same
// cycle returns the old contents.
// Ports:
//   clk    in  clock, write on posedge
//   we     in  write enable
//   addr   in  word index (shared by read and write)
//   wdata  in  write data
//   rdata  out read data
module data_mem #(
  parameter int DPW   = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DPW-1:0]           wdata,
  output logic [DPW-1:0]           rdata
);

  logic [DPW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access and writeback end of the rv32i pipeline.
// Performs the data memory access for the M-stage instruction, registers
// the M/W stage, drives the reg-file write port and exports the W-stage
// result for forwarding. Also keeps saturating load/store counters.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, misaligned loads
// and stores are trapped (store dropped, regwrite squashed, sticky
// misalign_err). When undefined, addresses are aligned down and
// misalign_err is tied 0.
// Ports:
//   clk    in   clock, all state on posedge
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of mem_wb_stage_if (M-stage inputs, W-stage
//          reg-file port, hazard/forwarding outputs, counters, error flag)
module mem_wb_stage #(
  parameter int DMEM_DEPTH = rv32i_pkg::DMEM_DEPTH,
  parameter int CNTW       = rv32i_pkg::CNTW
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_wb_stage_if.slave  bus
);
  import rv32i_pkg::*;

  localparam int IDXW = $clog2(DMEM_DEPTH);

  logic [IDXW-1:0] idx;
  logic [DPW-1:0]  readdata;
  logic            is_load;
  logic            is_store;
  logic            misalign;
  logic            store_en;

  mw_reg_t         mw_d, mw_q;
  logic [CNTW-1:0] load_cnt_d, load_cnt_q;
  logic [CNTW-1:0] store_cnt_d, store_cnt_q;

  // Upper address bits wrap; the byte offset only matters for the trap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.aluresultM[DPW-1:IDXW+2], bus.aluresultM[1:0]};

  assign idx      = bus.aluresultM[IDXW+1:2];
  assign is_load  = bus.regwriteM & bus.resultsrcM;
  assign is_store = bus.memwriteM;

`ifdef MISALIGN_TRAP_EN
  assign misalign = (is_load | is_store) & addr_misaligned(bus.aluresultM[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // No store may land while the pipeline is being reset.
  assign store_en = rst_n & is_store & ~misalign;

  data_mem #(
    .DPW   (DPW),
    .DEPTH (DMEM_DEPTH)
  ) u_dmem (
    .clk   (clk),
    .we    (store_en),
    .addr  (idx),
    .wdata (bus.Rd2M),
    .rdata (readdata)
  );

  always_comb begin
    mw_d           = '0;
    mw_d.regwrite  = bus.regwriteM & ~misalign;
    mw_d.resultsrc = bus.resultsrcM;
    mw_d.aluresult = bus.aluresultM;
    mw_d.readdata  = readdata;
    mw_d.rd        = bus.RdM;
  end

  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (is_load && !misalign && (load_cnt_q != {CNTW{1'b1}})) begin
      load_cnt_d = load_cnt_q + 1'b1;
    end
    if (is_store && !misalign && (store_cnt_q != {CNTW{1'b1}})) begin
      store_cnt_d = store_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mw_q        <= '0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      mw_q        <= mw_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_err_d, misalign_err_q;

  assign misalign_err_d = misalign_err_q | misalign;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_err_q <= 1'b0;
    end else begin
      misalign_err_q <= misalign_err_d;
    end
  end

  assign bus.misalign_err = misalign_err_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

  assign bus.resultW   = mw_q.resultsrc ? mw_q.readdata : mw_q.aluresult;
  assign bus.wd_3      = bus.resultW;
  assign bus.addr_3    = mw_q.rd[ADW-1:0];
  assign bus.RdW       = mw_q.rd;
  assign bus.regwriteW = mw_q.regwrite;
  // x0 is hardwired zero, so a write to it is never issued.
  assign bus.we        = mw_q.regwrite & (mw_q.rd != 5'd0);
  assign bus.load_cnt  = load_cnt_q;
  assign bus.store_cnt = store_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed bench for mem_wb_stage with a
// behavioural reference model (word array + expected W-stage outputs).
// Uses a narrow counter width so saturation is reachable quickly.
module tb_mem_wb_stage;
  localparam int DEPTH   = 256;
  localparam int TB_CNTW = 4;
  localparam int CMAX    = (1 << TB_CNTW) - 1;

  logic clk;
  logic rst_n;

  mem_wb_stage_if #(.CNTW(TB_CNTW)) bus ();

  mem_wb_stage #(
    .DMEM_DEPTH (DEPTH),
    .CNTW       (TB_CNTW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // reference model state
  logic [31:0] m_mem [DEPTH];
  logic        e_rw;
  logic        e_we;
  logic [31:0] e_res;
  logic [4:0]  e_rd;
  int          e_lc;
  int          e_sc;
  logic        e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic rst, input logic rw, input logic rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] d, input logic [4:0] rd);
    int          w;
    logic        mis;
    logic [31:0] old;
    if (!rst) begin
      e_rw = 0; e_res = 0; e_rd = 0; e_lc = 0; e_sc = 0; e_err = 0;
    end else begin
      w = int'((alu % 32'(DEPTH * 4)) / 4);
`ifdef MISALIGN_TRAP_EN
      mis = (mw || (rw && rs)) && (alu % 4 != 0);
`else
      mis = 1'b0;
`endif
      old   = m_mem[w];
      e_res = rs ? old : alu;
      e_rd  = rd;
      e_rw  = rw && !mis;
      if (mw && !mis) m_mem[w] = d;
      if (rw && rs && !mis && e_lc < CMAX) e_lc++;
      if (mw && !mis && e_sc < CMAX) e_sc++;
      if (mis) e_err = 1'b1;
    end
    e_we = e_rw && (e_rd != 0);
  endtask

  task automatic cyc(input logic rst, input logic rw, input logic rs, input logic mw,
                     input logic [31:0] alu, input logic [31:0] d, input logic [4:0] rd);
    @(negedge clk);
    rst_n          = rst;
    bus.regwriteM  = rw;
    bus.resultsrcM = rs;
    bus.memwriteM  = mw;
    bus.aluresultM = alu;
    bus.Rd2M       = d;
    bus.RdM        = rd;
    @(posedge clk);
    #1;
    model(rst, rw, rs, mw, alu, d, rd);
    check("we",        32'(bus.we),           32'(e_we));
    check("addr_3",    32'(bus.addr_3),       32'(e_rd));
    check("wd_3",      bus.wd_3,              e_res);
    check("resultW",   bus.resultW,           e_res);
    check("RdW",       32'(bus.RdW),          32'(e_rd));
    check("regwriteW", 32'(bus.regwriteW),    32'(e_rw));
    check("load_cnt",  32'(bus.load_cnt),     32'(e_lc));
    check("store_cnt", 32'(bus.store_cnt),    32'(e_sc));
    check("misalign",  32'(bus.misalign_err), 32'(e_err));
  endtask

  initial begin
    logic [31:0] saved;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.regwriteM = 0; bus.resultsrcM = 0; bus.memwriteM = 0;
    bus.aluresultM = 0; bus.Rd2M = 0; bus.RdM = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

    // reset state
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // fill memory so every later load has a known value
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 1, 32'(i * 4), $urandom, 0);
    check("sat_store_cnt", 32'(bus.store_cnt), 32'(CMAX));
    cyc(0, 0, 0, 0, 0, 0, 0);

    // store then load
    cyc(1, 0, 0, 1, 32'h10, 32'hDEADBEEF, 0);
    cyc(1, 1, 1, 0, 32'h10, 0, 5);
    check("t1_we",  32'(bus.we), 1);
    check("t1_rd",  32'(bus.addr_3), 5);
    check("t1_wd",  bus.wd_3, 32'hDEADBEEF);
    check("t1_lc",  32'(bus.load_cnt), 1);
    check("t1_sc",  32'(bus.store_cnt), 1);

    // ALU writeback
    cyc(1, 1, 0, 0, 32'h1234, 0, 7);
    check("t2_we", 32'(bus.we), 1);
    check("t2_rd", 32'(bus.addr_3), 7);
    check("t2_wd", bus.wd_3, 32'h1234);

    // x0 suppression
    cyc(1, 1, 0, 0, 32'hFFFF, 0, 0);
    check("t3_we",  32'(bus.we), 0);
    check("t3_res", bus.resultW, 32'hFFFF);

    // address wrap
    cyc(1, 0, 0, 1, 32'h400, 32'hA5A5A5A5, 0);
    cyc(1, 1, 1, 0, 32'h000, 0, 3);
    check("t4_wd", bus.wd_3, 32'hA5A5A5A5);

    // reset mid-op, store during reset must not land
    saved = m_mem[8];
    cyc(0, 1, 1, 0, 32'h20, 0, 9);
    check("t5_wd", bus.wd_3, 0);
    check("t5_we", 32'(bus.we), 0);
    cyc(0, 0, 0, 1, 32'h20, 32'h5555AAAA, 0);
    cyc(1, 1, 1, 0, 32'h20, 0, 9);
    check("t5_mem", bus.wd_3, saved);
    check("t5_sc",  32'(bus.store_cnt), 0);

    // misaligned store
    cyc(1, 0, 0, 1, 32'h12, 32'h11111111, 0);
`ifdef MISALIGN_TRAP_EN
    check("t6_err", 32'(bus.misalign_err), 1);
    check("t6_sc",  32'(bus.store_cnt), 0);
`else
    check("t6_err", 32'(bus.misalign_err), 0);
    check("t6_sc",  32'(bus.store_cnt), 1);
`endif
    cyc(1, 1, 1, 0, 32'h10, 0, 4);
`ifdef MISALIGN_TRAP_EN
    check("t6_mem", bus.wd_3, 32'hDEADBEEF);
    check("t6_sticky", 32'(bus.misalign_err), 1);
`else
    check("t6_mem", bus.wd_3, 32'h11111111);
    check("t6_sticky", 32'(bus.misalign_err), 0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(1, 0) == 0) a[1:0] = 2'b00;
      cyc(($urandom_range(31, 0) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
          a, $urandom, 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
